// File: rtl/ysyx_25040111_csr_pkg.sv
// Shared constants for the machine-mode CSR unit.
// Holds CSR addresses, request op codes, FSM state encodings,
// mstatus bit positions and a helper that assembles the mstatus read value.
package ysyx_25040111_csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    // Request op codes
    localparam logic [2:0] OP_CSRRW  = 3'd1;
    localparam logic [2:0] OP_CSRRS  = 3'd2;
    localparam logic [2:0] OP_ECALL  = 3'd3;
    localparam logic [2:0] OP_MRET   = 3'd4;
    localparam logic [2:0] OP_EBREAK = 3'd5;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // mstatus fields
    localparam int         MSTATUS_MIE   = 3;
    localparam int         MSTATUS_MPIE  = 7;
    localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

    // Only MIE/MPIE are stored; MPP is fixed to M-mode, everything else reads 0.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v               = '0;
        v[12:11]        = MSTATUS_MPP_M;
        v[MSTATUS_MIE]  = mie;
        v[MSTATUS_MPIE] = mpie;
        return v;
    endfunction

endpackage

// File: rtl/ysyx_25040111_csr_file.sv
// M-mode CSR storage with combinational read mux and masked write port.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   addr_i             : CSR address for both read and generic write
//   rdata_o/hit_o/ro_o : current value, address-known flag, read-only flag
//   wen_i, wdata_i     : generic CSR write (masked per CSR)
//   ecall_i, epc_i, cause_i : trap entry update of mepc/mcause/mstatus
//   mret_i             : trap return update of mstatus
//   mtvec_o, mepc_o    : trap/return targets
module ysyx_25040111_csr_file
    import ysyx_25040111_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0,
    parameter logic [31:0] MVENDORID = 32'h0,
    parameter logic [31:0] MARCHID   = 32'h0190_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] addr_i,
    output logic [31:0] rdata_o,
    output logic        hit_o,
    output logic        ro_o,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic        ecall_i,
    input  logic [31:0] epc_i,
    input  logic [3:0]  cause_i,
    input  logic        mret_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

    always_comb begin
        rdata_o = '0;
        hit_o   = 1'b1;
        ro_o    = 1'b0;
        case (addr_i)
            CSR_MSTATUS:   rdata_o = mstatus_pack(mie_q, mpie_q);
            CSR_MTVEC:     rdata_o = mtvec_q;
            CSR_MSCRATCH:  rdata_o = mscratch_q;
            CSR_MEPC:      rdata_o = mepc_q;
            CSR_MCAUSE:    rdata_o = mcause_q;
            CSR_MVENDORID: begin rdata_o = MVENDORID; ro_o = 1'b1; end
            CSR_MARCHID:   begin rdata_o = MARCHID;   ro_o = 1'b1; end
            default:       hit_o = 1'b0;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (wen_i) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mie_d  = wdata_i[MSTATUS_MIE];
                    mpie_d = wdata_i[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = wdata_i & ~32'h3;
                CSR_MSCRATCH: mscratch_d = wdata_i;
                CSR_MEPC:     mepc_d     = wdata_i & ~32'h3;
                CSR_MCAUSE:   mcause_d   = wdata_i;
                default: ;
            endcase
        end
        if (ecall_i) begin
            mepc_d   = epc_i & ~32'h3;
            mcause_d = {28'b0, cause_i};
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
        if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

endmodule

// File: rtl/ysyx_25040111_csr.sv
// Machine-mode CSR execution unit: executes CSRRW/CSRRS, ECALL, MRET and
// EBREAK requests from decode and returns results/redirects to writeback.
// Ports:
//   clock, reset                  : clock and synchronous active-high reset
//   in_valid/in_ready             : request handshake
//   in_op, in_csr, in_wdata, in_rs1_zero, in_pc, in_cause : request fields
//   out_valid/out_ready           : response handshake
//   out_rdata, out_redirect, out_npc, out_illegal, out_ebreak : response fields
module ysyx_25040111_csr
    import ysyx_25040111_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0,
    parameter logic [31:0] MVENDORID = 32'h0,
    parameter logic [31:0] MARCHID   = 32'h0190_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [11:0] in_csr,
    input  logic [31:0] in_wdata,
    input  logic        in_rs1_zero,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_cause,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_redirect,
    output logic [31:0] out_npc,
    output logic        out_illegal,
    output logic        out_ebreak
);

    logic [1:0]  state_q, state_d;

    // Latched request
    logic [2:0]  op_q;
    logic [11:0] csr_q;
    logic [31:0] wdata_q;
    logic        rs1z_q;
    logic [31:0] pc_q;
    logic [3:0]  cause_q;

    // Latched response
    logic [31:0] rdata_q, npc_q;
    logic        redirect_q, illegal_q, ebreak_q;

    // Execute-stage decode
    logic [31:0] f_rdata, f_mtvec, f_mepc;
    logic        f_hit, f_ro;
    logic        x_wen, x_ecall, x_mret;
    logic [31:0] x_wdata, x_rdata, x_npc;
    logic        x_redirect, x_illegal, x_ebreak;

    ysyx_25040111_csr_file #(
        .MTVEC_RST (MTVEC_RST),
        .MVENDORID (MVENDORID),
        .MARCHID   (MARCHID)
    ) u_file (
        .clock   (clock),
        .reset   (reset),
        .addr_i  (csr_q),
        .rdata_o (f_rdata),
        .hit_o   (f_hit),
        .ro_o    (f_ro),
        .wen_i   (x_wen),
        .wdata_i (x_wdata),
        .ecall_i (x_ecall),
        .epc_i   (pc_q),
        .cause_i (cause_q),
        .mret_i  (x_mret),
        .mtvec_o (f_mtvec),
        .mepc_o  (f_mepc)
    );

    // Side effects are only enabled in EXEC, so a stalled RESP never repeats them.
    always_comb begin
        x_wen      = 1'b0;
        x_wdata    = '0;
        x_ecall    = 1'b0;
        x_mret     = 1'b0;
        x_rdata    = '0;
        x_redirect = 1'b0;
        x_npc      = '0;
        x_illegal  = 1'b0;
        x_ebreak   = 1'b0;
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_CSRRW: begin
                    if (!f_hit || f_ro) begin
                        x_illegal = 1'b1;
                    end else begin
                        x_rdata = f_rdata;
                        x_wen   = 1'b1;
                        x_wdata = wdata_q;
                    end
                end
                OP_CSRRS: begin
                    // With rs1=x0 there is no write, so read-only CSRs are readable.
                    if (!f_hit || (f_ro && !rs1z_q)) begin
                        x_illegal = 1'b1;
                    end else begin
                        x_rdata = f_rdata;
                        x_wen   = !rs1z_q;
                        x_wdata = f_rdata | wdata_q;
                    end
                end
                OP_ECALL: begin
                    x_ecall    = 1'b1;
                    x_redirect = 1'b1;
                    x_npc      = f_mtvec;
                end
                OP_MRET: begin
                    x_mret     = 1'b1;
                    x_redirect = 1'b1;
                    x_npc      = f_mepc;
                end
                OP_EBREAK: x_ebreak  = 1'b1;
                default:   x_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rdata_q    <= '0;
            npc_q      <= '0;
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
            ebreak_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_EXEC) begin
                rdata_q    <= x_rdata;
                npc_q      <= x_npc;
                redirect_q <= x_redirect;
                illegal_q  <= x_illegal;
                ebreak_q   <= x_ebreak;
            end
        end
    end

    // Request fields are captured only on the accept edge.
    always_ff @(posedge clock) begin
        if (state_q == ST_IDLE && in_valid) begin
            op_q    <= in_op;
            csr_q   <= in_csr;
            wdata_q <= in_wdata;
            rs1z_q  <= in_rs1_zero;
            pc_q    <= in_pc;
            cause_q <= in_cause;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_RESP);
    assign out_rdata    = rdata_q;
    assign out_redirect = redirect_q;
    assign out_npc      = npc_q;
    assign out_illegal  = illegal_q;
    assign out_ebreak   = ebreak_q;

endmodule

// File: tb/tb_ysyx_25040111_csr.sv
// Testbench for ysyx_25040111_csr: directed request table plus stall and
// reset-in-EXEC sequences.
module tb_ysyx_25040111_csr;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [11:0] in_csr;
    logic [31:0] in_wdata;
    logic        in_rs1_zero;
    logic [31:0] in_pc;
    logic [3:0]  in_cause;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_redirect;
    logic [31:0] out_npc;
    logic        out_illegal;
    logic        out_ebreak;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] csr;
        logic [31:0] wdata;
        logic        rs1z;
        logic [31:0] pc;
        logic [3:0]  cause;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] npc;
        logic        ill;
        logic        ebk;
    } vec_t;

    vec_t vecs[$];

    ysyx_25040111_csr dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_csr       (in_csr),
        .in_wdata     (in_wdata),
        .in_rs1_zero  (in_rs1_zero),
        .in_pc        (in_pc),
        .in_cause     (in_cause),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rdata    (out_rdata),
        .out_redirect (out_redirect),
        .out_npc      (out_npc),
        .out_illegal  (out_illegal),
        .out_ebreak   (out_ebreak)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] wdata,
                       input logic rs1z, input logic [31:0] pc, input logic [3:0] cause,
                       input logic [31:0] rdata, input logic redir, input logic [31:0] npc,
                       input logic ill, input logic ebk);
        vec_t v;
        v.op = op; v.csr = csr; v.wdata = wdata; v.rs1z = rs1z; v.pc = pc; v.cause = cause;
        v.rdata = rdata; v.redir = redir; v.npc = npc; v.ill = ill; v.ebk = ebk;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) chk({tag, " ready timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Drives one request and leaves the bench one step after the accept edge (EXEC).
    task automatic send(input vec_t v, input string tag);
        wait_ready(tag);
        in_op       = v.op;
        in_csr      = v.csr;
        in_wdata    = v.wdata;
        in_rs1_zero = v.rs1z;
        in_pc       = v.pc;
        in_cause    = v.cause;
        in_valid    = 1'b1;
        @(posedge clock); #1;
        in_valid    = 1'b0;
        // Scramble inputs after accept; the unit must not resample them.
        in_op       = 3'd0;
        in_csr      = 12'hFFF;
        in_wdata    = 32'hFFFF_FFFF;
        in_rs1_zero = ~v.rs1z;
        in_pc       = 32'hDEAD_BEE0;
        in_cause    = 4'hF;
    endtask

    task automatic check_resp(input vec_t v, input string tag);
        chk({tag, " valid"},    32'(out_valid),    32'd1);
        chk({tag, " rdata"},    out_rdata,         v.rdata);
        chk({tag, " redirect"}, 32'(out_redirect), 32'(v.redir));
        if (v.redir) chk({tag, " npc"}, out_npc, v.npc);
        chk({tag, " illegal"},  32'(out_illegal),  32'(v.ill));
        chk({tag, " ebreak"},   32'(out_ebreak),   32'(v.ebk));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, " valid after ack"}, 32'(out_valid), 32'd0);
        chk({tag, " ready after ack"}, 32'(in_ready),  32'd1);
    endtask

    task automatic run(input vec_t v, input string tag);
        send(v, tag);
        chk({tag, " exec busy"}, {30'd0, in_ready, out_valid}, 32'd0);
        @(posedge clock); #1;
        check_resp(v, tag);
        handshake(tag);
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_csr = 12'h0; in_wdata = 32'h0; in_rs1_zero = 1'b0;
        in_pc = 32'h0; in_cause = 4'h0;

        //   op    csr      wdata         z  pc            cs  rdata         rd npc           il eb
        add(3'd2, 12'h300, 32'h0,         1, 32'h0,        0, 32'h0000_1800, 0, 32'h0,        0, 0);
        add(3'd1, 12'h305, 32'h8000_0103, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 0);
        add(3'd2, 12'h305, 32'h0,         1, 32'h0,        0, 32'h8000_0100, 0, 32'h0,        0, 0);
        add(3'd2, 12'h300, 32'h8,         0, 32'h0,        0, 32'h0000_1800, 0, 32'h0,        0, 0);
        add(3'd3, 12'h000, 32'h0,         0, 32'h8000_0040,11, 32'h0,         1, 32'h8000_0100, 0, 0);
        add(3'd2, 12'h341, 32'h0,         1, 32'h0,        0, 32'h8000_0040, 0, 32'h0,        0, 0);
        add(3'd2, 12'h342, 32'h0,         1, 32'h0,        0, 32'h0000_000B, 0, 32'h0,        0, 0);
        add(3'd2, 12'h300, 32'h0,         1, 32'h0,        0, 32'h0000_1880, 0, 32'h0,        0, 0);
        add(3'd4, 12'h000, 32'h0,         0, 32'h0,        0, 32'h0,         1, 32'h8000_0040, 0, 0);
        add(3'd2, 12'h300, 32'h0,         1, 32'h0,        0, 32'h0000_1888, 0, 32'h0,        0, 0);
        add(3'd1, 12'hF11, 32'h0000_DEAD, 0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 0);
        add(3'd1, 12'h7C0, 32'h5,         0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 0);
        add(3'd2, 12'hF12, 32'h0,         1, 32'h0,        0, 32'h0190_0000, 0, 32'h0,        0, 0);
        add(3'd2, 12'hF11, 32'h0,         1, 32'h0,        0, 32'h0,         0, 32'h0,        0, 0);
        add(3'd2, 12'hF11, 32'h1,         0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 0);
        add(3'd2, 12'h305, 32'h0,         1, 32'h0,        0, 32'h8000_0100, 0, 32'h0,        0, 0);
        add(3'd5, 12'h000, 32'h0,         0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 1);
        add(3'd0, 12'h300, 32'h8,         0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 0);
        add(3'd7, 12'h300, 32'h8,         0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 0);
        add(3'd2, 12'h300, 32'h0,         1, 32'h0,        0, 32'h0000_1888, 0, 32'h0,        0, 0);
        add(3'd1, 12'h340, 32'hA5A5_0000, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 0);
        add(3'd1, 12'h341, 32'h1234_5677, 0, 32'h0,        0, 32'h8000_0040, 0, 32'h0,        0, 0);
        add(3'd2, 12'h341, 32'h0,         1, 32'h0,        0, 32'h1234_5674, 0, 32'h0,        0, 0);
        add(3'd1, 12'h300, 32'hFFFF_FFFF, 0, 32'h0,        0, 32'h0000_1888, 0, 32'h0,        0, 0);
        add(3'd2, 12'h300, 32'h0,         1, 32'h0,        0, 32'h0000_1888, 0, 32'h0,        0, 0);
        add(3'd1, 12'h300, 32'h0,         0, 32'h0,        0, 32'h0000_1888, 0, 32'h0,        0, 0);
        add(3'd2, 12'h300, 32'h0,         1, 32'h0,        0, 32'h0000_1800, 0, 32'h0,        0, 0);
        add(3'd1, 12'h342, 32'hFFFF_FFFF, 0, 32'h0,        0, 32'h0000_000B, 0, 32'h0,        0, 0);
        add(3'd2, 12'h342, 32'h0,         1, 32'h0,        0, 32'hFFFF_FFFF, 0, 32'h0,        0, 0);
        add(3'd3, 12'h000, 32'h0,         0, 32'h0000_0106, 3, 32'h0,         1, 32'h8000_0100, 0, 0);
        add(3'd2, 12'h341, 32'h0,         1, 32'h0,        0, 32'h0000_0104, 0, 32'h0,        0, 0);
        add(3'd2, 12'h342, 32'h0,         1, 32'h0,        0, 32'h0000_0003, 0, 32'h0,        0, 0);
        add(3'd2, 12'h300, 32'h0,         1, 32'h0,        0, 32'h0000_1800, 0, 32'h0,        0, 0);
        add(3'd2, 12'h340, 32'h0,         1, 32'h0,        0, 32'hA5A5_0000, 0, 32'h0,        0, 0);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst in_ready",     32'(in_ready),     32'd1);
        chk("rst out_valid",    32'(out_valid),    32'd0);
        chk("rst out_rdata",    out_rdata,         32'd0);
        chk("rst out_redirect", 32'(out_redirect), 32'd0);
        chk("rst out_npc",      out_npc,           32'd0);
        chk("rst out_illegal",  32'(out_illegal),  32'd0);
        chk("rst out_ebreak",   32'(out_ebreak),   32'd0);

        foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

        // Stall in RESP: CSRRS mscratch |= 1, response must hold for 5 cycles
        v.op = 3'd2; v.csr = 12'h340; v.wdata = 32'h1; v.rs1z = 1'b0; v.pc = 32'h0; v.cause = 4'h0;
        v.rdata = 32'hA5A5_0000; v.redir = 1'b0; v.npc = 32'h0; v.ill = 1'b0; v.ebk = 1'b0;
        send(v, "stall");
        @(posedge clock); #1;
        for (int k = 0; k < 5; k++) begin
            check_resp(v, $sformatf("stall%0d", k));
            chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            @(posedge clock); #1;
        end
        handshake("stall");
        v.wdata = 32'h0; v.rs1z = 1'b1; v.rdata = 32'hA5A5_0001;
        run(v, "stall readback");

        // Reset asserted while in EXEC
        v.op = 3'd1; v.csr = 12'h340; v.wdata = 32'h55; v.rs1z = 1'b0; v.rdata = 32'h0;
        send(v, "rstexec");
        chk("rstexec in EXEC", {30'd0, in_ready, out_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rstexec out_valid", 32'(out_valid), 32'd0);
        chk("rstexec in_ready",  32'(in_ready),  32'd1);
        chk("rstexec out_rdata", out_rdata,      32'd0);
        v.op = 3'd2; v.wdata = 32'h0; v.rs1z = 1'b1; v.rdata = 32'h0;
        run(v, "rstexec mscratch");
        v.csr = 12'h300; v.rdata = 32'h0000_1800;
        run(v, "rstexec mstatus");
        v.csr = 12'h305; v.rdata = 32'h0;
        run(v, "rstexec mtvec");
        v.csr = 12'h341; v.rdata = 32'h0;
        run(v, "rstexec mepc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
